// File: rtl/draw_layer_arbiter.sv
// Fixed-priority per-pixel RGB arbiter for NUM_LAYERS draw layers.
// Two-stage pipeline plus per-frame collision mask and frame counter.
//
// Ports:
//   clk, resetN          pixel clock, async active-low reset
//   pxl_x, pxl_y         current pixel from vga_controller
//   disp_ena             active-video flag
//   req_draw, req_rgb    per-layer draw flags and {R,G,B}; layer 0 wins
//   Red/Green/Blue/Draw  arbitrated pixel, layer_id = winning layer
//   coll_mask/coll_valid layers that overlapped last frame, 1-cycle pulse
//   frame_cnt            completed-frame counter (wraps)
//
// Optional feature: define DRAW_ARB_COLL_EN to build the collision
// accumulator; otherwise coll_mask and coll_valid are tied to 0.
module draw_layer_arbiter #(
  parameter int          NUM_LAYERS = 4,
  parameter int          WIDTH      = 640,
  parameter int          HEIGHT     = 480,
  parameter logic [11:0] BG_RGB     = 12'h000,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [XW-1:0]           pxl_x,
  input  logic [YW-1:0]           pxl_y,
  input  logic                    disp_ena,
  input  logic [NUM_LAYERS-1:0]   req_draw,
  input  logic [12*NUM_LAYERS-1:0] req_rgb,
  output logic [3:0]              Red,
  output logic [3:0]              Green,
  output logic [3:0]              Blue,
  output logic                    Draw,
  output logic [LW-1:0]           layer_id,
  output logic [NUM_LAYERS-1:0]   coll_mask,
  output logic                    coll_valid,
  output logic [15:0]             frame_cnt
);

  logic [NUM_LAYERS-1:0]    req_q;
  logic [12*NUM_LAYERS-1:0] rgb_q;
  logic                     ena_q;
  logic                     org_q;
  logic                     fs_q;
  logic                     origin;

  assign origin = (pxl_x == '0) && (pxl_y == '0);

  // org_q resets to "at origin" so a held or reset-time origin
  // never fires; only an arrival at (0,0) starts a frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_q <= '0;
      rgb_q <= '0;
      ena_q <= 1'b0;
      org_q <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      req_q <= req_draw & {NUM_LAYERS{disp_ena}};
      rgb_q <= req_rgb;
      ena_q <= disp_ena;
      org_q <= origin;
      fs_q  <= origin & ~org_q;
    end
  end

  logic [LW-1:0] win;
  logic          hit;
  logic [11:0]   win_rgb;

  // Scan high to low so the lowest set index is the last to land.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req_q[i]) begin
        win = LW'(i);
        hit = 1'b1;
      end
    end
  end

  assign win_rgb = rgb_q[12*int'(win) +: 12];

  logic [11:0] pix_d, pix_q;
  logic        draw_q;
  logic [LW-1:0] id_q;
  logic [15:0] cnt_q;

  always_comb begin
    pix_d = 12'h000;
    if (hit)        pix_d = win_rgb;
    else if (ena_q) pix_d = BG_RGB;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_q  <= '0;
      draw_q <= 1'b0;
      id_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pix_q  <= pix_d;
      draw_q <= hit;
      id_q   <= win;
      if (fs_q) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign Red       = pix_q[11:8];
  assign Green     = pix_q[7:4];
  assign Blue      = pix_q[3:0];
  assign Draw      = draw_q;
  assign layer_id  = id_q;
  assign frame_cnt = cnt_q;

`ifdef DRAW_ARB_COLL_EN
  logic [NUM_LAYERS-1:0] acc_q, mask_q;
  logic                  valid_q;
  logic                  ovl;

  // Two or more bits set <=> clearing the lowest set bit leaves some.
  assign ovl = |(req_q & (req_q - 1'b1));

  // On frame start the origin pixel already belongs to the new
  // frame: acc restarts from its overlap rather than from zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= fs_q;
      if (fs_q) begin
        mask_q <= acc_q;
        acc_q  <= ovl ? req_q : '0;
      end else if (ovl) begin
        acc_q  <= acc_q | req_q;
      end
    end
  end

  assign coll_mask  = mask_q;
  assign coll_valid = valid_q;
`else
  assign coll_mask  = '0;
  assign coll_valid = 1'b0;
`endif

endmodule
